// File: rtl/cic_integrator_decimator_if.sv
// ----------------------------------------------------------------------------
// cic_integrator_decimator_if
//
// Sample and strobe bundle between a sample source and the CIC integrator or
// decimator. The integrator's y_out and out_valid feed the comb chain's x_in
// and ena.
//
//   ena        source -> filter   global enable; 0 freezes the filter
//   in_valid   source -> filter   x_in carries a new sample this cycle
//   x_in       source -> filter   signed input sample, IN_WIDTH bits
//   y_out      filter -> sink     decimated integrator output, WIDTH bits
//   out_valid  filter -> sink     one-cycle strobe, y_out updated
//
// master: sample source / sink side (testbench, upstream logic)
// slave : the filter
// ----------------------------------------------------------------------------
interface cic_integrator_decimator_if #(
    parameter int IN_WIDTH = 16,
    parameter int WIDTH    = 32
);
    logic                ena;
    logic                in_valid;
    logic [IN_WIDTH-1:0] x_in;
    logic [WIDTH-1:0]    y_out;
    logic                out_valid;

    modport master (
        output ena,
        output in_valid,
        output x_in,
        input  y_out,
        input  out_valid
    );

    modport slave (
        input  ena,
        input  in_valid,
        input  x_in,
        output y_out,
        output out_valid
    );
endinterface

// File: rtl/cic_integrator_decimator.sv
// ----------------------------------------------------------------------------
// cic_integrator_decimator
//
// Front half of a CIC decimator. STAGES cascaded integrators run at the input
// rate. The block keeps one output out of every RATE accepted samples. Each
// output is a wide sample with a one-cycle strobe, and the result goes straight
// into the comb chain.
//
// Ports
//   clock   input   filter clock; all state changes on the rising edge
//   reset   input   asynchronous, active-low; clears all state
//   bus     slave   ena / in_valid / x_in in, y_out / out_valid out
//
// Parameters
//   IN_WIDTH  width of the signed input sample
//   STAGES    number of integrators (>= 1)
//   RATE      decimation factor (>= 2)
//   WIDTH     internal/output width, >= IN_WIDTH + STAGES*$clog2(RATE)
//
// Arithmetic wraps modulo 2^WIDTH. This is intentional: the downstream combs
// difference the wrapped values and recover the true result, provided WIDTH
// meets the growth bound above.
// ----------------------------------------------------------------------------
module cic_integrator_decimator #(
    parameter int IN_WIDTH = 16,
    parameter int STAGES   = 3,
    parameter int RATE     = 8,
    parameter int WIDTH    = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    cic_integrator_decimator_if.slave    bus
);

    localparam int               PH_W    = $clog2(RATE);
    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(RATE - 1);

    logic [WIDTH-1:0] integ_q [STAGES];
    logic [WIDTH-1:0] integ_d [STAGES];
    logic [PH_W-1:0]  phase_q;
    logic [PH_W-1:0]  phase_d;
    logic [WIDTH-1:0] y_q;
    logic             out_valid_q;

    logic             accept;
    logic             phase_last;
    logic [WIDTH-1:0] x_ext;

    assign accept     = bus.ena & bus.in_valid;
    assign phase_last = (phase_q == PH_LAST);
    assign x_ext      = {{(WIDTH - IN_WIDTH){bus.x_in[IN_WIDTH-1]}}, bus.x_in};

    // Every stage adds the previous value of the stage before it. This makes a
    // pipelined cascade, so a sample reaches the last stage STAGES-1 accepts
    // after it enters.
    always_comb begin
        integ_d[0] = integ_q[0] + x_ext;
        for (int k = 1; k < STAGES; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
        // The explicit wrap lets RATE be a non-power of two.
        phase_d = phase_last ? '0 : phase_q + PH_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                integ_q[k] <= '0;
            end
            phase_q     <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // The strobe is computed on every edge, not only on accepts. It
            // therefore drops after one cycle, and it stays low while ena is 0.
            out_valid_q <= accept & phase_last;
            if (accept) begin
                for (int k = 0; k < STAGES; k++) begin
                    integ_q[k] <= integ_d[k];
                end
                phase_q <= phase_d;
                // The output is the updated value of the last stage.
                if (phase_last) begin
                    y_q <= integ_d[STAGES-1];
                end
            end
        end
    end

    assign bus.y_out     = y_q;
    assign bus.out_valid = out_valid_q;

endmodule
